// File: rtl/mvm_pkg.sv
// Shared types, default geometry and post-processing for the tiled matrix-vector engine.
// Address layout of a weight write is {tile, row, col} with col in the low bits.
package mvm_pkg;

    localparam int MVM_DW     = 8;
    localparam int MVM_ROWS   = 32;
    localparam int MVM_COLS   = 8;
    localparam int MVM_K_MAX  = 4;
    localparam int MVM_ACC_W  = 24;
    localparam int MVM_OUT_W  = 16;

    localparam int MVM_ROW_W  = $clog2(MVM_ROWS);
    localparam int MVM_COL_W  = $clog2(MVM_COLS);
    localparam int MVM_TILE_W = $clog2(MVM_K_MAX);

    localparam int MVM_COL_LSB  = 0;
    localparam int MVM_ROW_LSB  = MVM_COL_W;
    localparam int MVM_TILE_LSB = MVM_COL_W + MVM_ROW_W;

    localparam logic signed [MVM_ACC_W-1:0] MVM_SAT_HI = MVM_ACC_W'((1 << (MVM_OUT_W - 1)) - 1);
    localparam logic signed [MVM_ACC_W-1:0] MVM_SAT_LO = MVM_ACC_W'(-(1 << (MVM_OUT_W - 1)));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_X,
        ST_MAC,
        ST_OUT
    } state_t;

    // ReLU first, then either clamp to the signed OUT_W range or keep the low bits.
    function automatic logic [MVM_OUT_W-1:0] sat_relu(input logic signed [MVM_ACC_W-1:0] acc,
                                                      input logic relu,
                                                      input logic sat);
        logic signed [MVM_ACC_W-1:0] v;
        v = (relu && (acc < 0)) ? '0 : acc;
        if (sat && (v > MVM_SAT_HI))
            return {1'b0, {(MVM_OUT_W-1){1'b1}}};
        if (sat && (v < MVM_SAT_LO))
            return {1'b1, {(MVM_OUT_W-1){1'b0}}};
        return v[MVM_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/mvm_row_lane.sv
// One output row: a K_MAX*COLS weight column, one signed multiplier and a wrapping accumulator.
// acc_nxt exposes the post-MAC value so the top can register results on the last MAC edge.
module mvm_row_lane
    import mvm_pkg::*;
#(
    parameter int DW    = MVM_DW,
    parameter int COLS  = MVM_COLS,
    parameter int K_MAX = MVM_K_MAX,
    parameter int ACC_W = MVM_ACC_W,
    localparam int IDX_W = $clog2(K_MAX * COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [IDX_W-1:0] raddr,
    input  logic [DW-1:0]    x,
    output logic [ACC_W-1:0] acc_nxt
);

    logic signed [DW-1:0]    w_mem [K_MAX*COLS];
    logic signed [ACC_W-1:0] acc;
    logic signed [2*DW-1:0]  prod;

    always_comb begin
        prod    = w_mem[raddr] * $signed(x);
        acc_nxt = acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K_MAX*COLS; i++)
                w_mem[i] <= '0;
        end else if (we) begin
            w_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc_nxt;
    end

endmodule

// File: rtl/mvm_tile_engine.sv
// Self-sequencing tiled matrix-vector engine: row-parallel lanes, one column per cycle,
// accumulation over 1..K_MAX input vectors, per-job ReLU and saturate/wrap on the result.
module mvm_tile_engine
    import mvm_pkg::*;
#(
    parameter int DW    = MVM_DW,
    parameter int ROWS  = MVM_ROWS,
    parameter int COLS  = MVM_COLS,
    parameter int K_MAX = MVM_K_MAX,
    parameter int ACC_W = MVM_ACC_W,
    parameter int OUT_W = MVM_OUT_W,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int COL_W  = $clog2(COLS),
    localparam int TILE_W = $clog2(K_MAX),
    localparam int IDX_W  = TILE_W + COL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [TILE_W+ROW_W+COL_W-1:0] cfg_addr,
    input  logic [DW-1:0]            cfg_data,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [TILE_W:0]          start_tiles,
    input  logic                     start_relu,
    input  logic                     start_sat,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [COLS*DW-1:0]       x_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ROWS*OUT_W-1:0]    res_data,
    output logic                     busy
);

    localparam logic [TILE_W:0] K_CAP = (TILE_W+1)'(K_MAX);

    state_t              state, state_nxt;
    logic                rdy_en;
    logic [TILE_W:0]     tiles;
    logic                relu_q, sat_q;
    logic [TILE_W-1:0]   tile_idx;
    logic [COL_W-1:0]    col_idx;
    logic [DW-1:0]       x_vec [COLS];
    logic [ACC_W-1:0]    acc_nxt [ROWS];
    logic [ROWS*OUT_W-1:0] res_q;

    logic cfg_fire, start_fire, x_fire, col_last, tile_last, job_done;
    logic [TILE_W-1:0] cfg_tile;
    logic [ROW_W-1:0]  cfg_row;
    logic [COL_W-1:0]  cfg_col;

    assign cfg_tile   = cfg_addr[MVM_TILE_LSB +: TILE_W];
    assign cfg_row    = cfg_addr[MVM_ROW_LSB +: ROW_W];
    assign cfg_col    = cfg_addr[MVM_COL_LSB +: COL_W];
    assign cfg_fire   = cfg_valid & cfg_ready;
    assign start_fire = start_valid & start_ready & (start_tiles != '0);
    assign x_fire     = x_valid & x_ready;
    assign col_last   = (col_idx == COL_W'(COLS - 1));
    assign tile_last  = ({1'b0, tile_idx} == (tiles - 1'b1));
    assign job_done   = (state == ST_MAC) && col_last && tile_last;
    assign res_data   = res_q;

    // Readies stay low during reset and for the cycle in which reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdy_en <= 1'b0;
        else
            rdy_en <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cfg_ready   = 1'b0;
        start_ready = 1'b0;
        x_ready     = 1'b0;
        res_valid   = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                cfg_ready   = rdy_en;
                start_ready = rdy_en;
                if (start_fire)
                    state_nxt = ST_WAIT_X;
            end
            ST_WAIT_X: begin
                x_ready = 1'b1;
                if (x_valid)
                    state_nxt = ST_MAC;
            end
            ST_MAC: begin
                if (col_last)
                    state_nxt = tile_last ? ST_OUT : ST_WAIT_X;
            end
            ST_OUT: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tiles    <= '0;
            relu_q   <= 1'b0;
            sat_q    <= 1'b0;
            tile_idx <= '0;
            col_idx  <= '0;
        end else if (start_fire) begin
            tiles    <= (start_tiles > K_CAP) ? K_CAP : start_tiles;
            relu_q   <= start_relu;
            sat_q    <= start_sat;
            tile_idx <= '0;
        end else if (x_fire) begin
            col_idx <= '0;
        end else if (state == ST_MAC) begin
            col_idx <= col_idx + 1'b1;
            if (col_last && !tile_last)
                tile_idx <= tile_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++)
                x_vec[c] <= '0;
        end else if (x_fire) begin
            for (int c = 0; c < COLS; c++)
                x_vec[c] <= x_data[c*DW +: DW];
        end
    end

    // Result captured from the post-MAC sums on the final MAC edge, stable through OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else if (job_done) begin
            for (int r = 0; r < ROWS; r++)
                res_q[r*OUT_W +: OUT_W] <= sat_relu(acc_nxt[r], relu_q, sat_q);
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        mvm_row_lane #(
            .DW    (DW),
            .COLS  (COLS),
            .K_MAX (K_MAX),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (start_fire),
            .en      (state == ST_MAC),
            .we      (cfg_fire && (cfg_row == ROW_W'(r))),
            .waddr   ({cfg_tile, cfg_col}),
            .wdata   (cfg_data),
            .raddr   ({tile_idx, col_idx}),
            .x       (x_vec[col_idx]),
            .acc_nxt (acc_nxt[r])
        );
    end

endmodule

// File: tb/tb_mvm_tile_engine.sv
// Directed bench for mvm_tile_engine: expected results are queued at job start and a
// negedge monitor compares them against each accepted result.
module tb_mvm_tile_engine;

    localparam int ROWS  = 32;
    localparam int COLS  = 8;
    localparam int DW    = 8;
    localparam int OUT_W = 16;
    localparam int RW    = ROWS * OUT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [9:0]        cfg_addr;
    logic [DW-1:0]     cfg_data;
    logic              start_valid;
    logic              start_ready;
    logic [2:0]        start_tiles;
    logic              start_relu;
    logic              start_sat;
    logic              x_valid;
    logic              x_ready;
    logic [COLS*DW-1:0] x_data;
    logic              res_valid;
    logic              res_ready;
    logic [RW-1:0]     res_data;
    logic              busy;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic [RW-1:0] exp_q[$];

    mvm_tile_engine dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_tiles (start_tiles),
        .start_relu  (start_relu),
        .start_sat   (start_sat),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_data      (x_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic logic [RW-1:0] rep(input logic [OUT_W-1:0] v);
        logic [RW-1:0] o;
        for (int r = 0; r < ROWS; r++) o[r*OUT_W +: OUT_W] = v;
        return o;
    endfunction

    function automatic logic [COLS*DW-1:0] xrep(input logic [DW-1:0] v);
        logic [COLS*DW-1:0] o;
        for (int c = 0; c < COLS; c++) o[c*DW +: DW] = v;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a result is consumed on the edge after a negedge with valid & ready.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0)
                timeout_fail("unexpected_result");
            else
                check("result", res_data, exp_q.pop_front());
        end
    end

    task automatic cfg_write(input int t, input int r, input int c, input logic [DW-1:0] d);
        int n = 0;
        while (!cfg_ready && n < 50) begin tick(); n++; end
        if (!cfg_ready) timeout_fail("cfg_ready_wait");
        cfg_valid = 1'b1;
        cfg_addr  = {t[1:0], r[4:0], c[2:0]};
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic fill_tile(input int t, input logic [DW-1:0] val, input bit diag);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                cfg_write(t, r, c, diag ? ((c == r % 8) ? 8'd1 : 8'd0) : val);
    endtask

    task automatic start_job(input logic [2:0] nt, input bit relu, input bit sat);
        int n = 0;
        while (!start_ready && n < 50) begin tick(); n++; end
        if (!start_ready) timeout_fail("start_ready_wait");
        start_valid = 1'b1;
        start_tiles = nt;
        start_relu  = relu;
        start_sat   = sat;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic send_x(input logic [COLS*DW-1:0] v, output int t_acc);
        int n = 0;
        x_valid = 1'b1;
        x_data  = v;
        while (!x_ready && n < 50) begin tick(); n++; end
        if (!x_ready) timeout_fail("x_ready_wait");
        t_acc = cyc;
        tick();
        x_valid = 1'b0;
    endtask

    task automatic wait_res(output int t);
        int n = 0;
        while (!res_valid && n < 100) begin tick(); n++; end
        if (!res_valid) timeout_fail("res_valid_wait");
        t = cyc;
    endtask

    initial begin
        logic [COLS*DW-1:0] xs;
        logic [RW-1:0]      ed;
        int t_acc, t_res, n;
        bit bad;

        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        start_valid = 1'b0; start_tiles = '0; start_relu = 1'b0; start_sat = 1'b0;
        x_valid = 1'b0; x_data = '0; res_ready = 1'b1;
        #1;
        check("reset_ctrl", RW'({cfg_ready, start_ready, x_ready, res_valid, busy}), '0);
        check("reset_res_data", res_data, '0);
        repeat (3) tick();
        rst = 1'b0;
        check("ready_after_release", RW'(cfg_ready), '0);
        tick();
        check("ready_first_clock", RW'({cfg_ready, start_ready}), RW'(2'b11));

        // One tile, diagonal weights, x = 1..8
        fill_tile(0, 8'd0, 1'b1);
        for (int c = 0; c < COLS; c++) xs[c*DW +: DW] = DW'(c + 1);
        for (int r = 0; r < ROWS; r++) ed[r*OUT_W +: OUT_W] = OUT_W'(r % 8 + 1);
        exp_q.push_back(ed);
        start_job(3'd1, 1'b0, 1'b1);
        send_x(xs, t_acc);
        wait_res(t_res);
        check("latency_1tile", RW'(t_res - t_acc), RW'(9));

        // Two tiles of ones, x0 = 2, x1 = 3 -> 40
        fill_tile(0, 8'd1, 1'b0);
        fill_tile(1, 8'd1, 1'b0);
        exp_q.push_back(rep(16'd40));
        start_job(3'd2, 1'b0, 1'b1);
        send_x(xrep(8'd2), t_acc);
        bad = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            if (x_ready !== 1'b0) bad = 1'b1;
            tick();
        end
        check("x_ready_low_mac0", RW'(bad), '0);
        check("x_ready_after_tile0", RW'(x_ready), RW'(1));
        send_x(xrep(8'd3), t_acc);
        bad = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            if (x_ready !== 1'b0) bad = 1'b1;
            tick();
        end
        check("x_ready_low_mac1", RW'(bad), '0);
        check("res_valid_after_tile1", RW'(res_valid), RW'(1));
        tick();

        // Four tiles of 127 x 127: saturate, then wrap with an over-range tile count
        for (int t = 0; t < 4; t++) fill_tile(t, 8'd127, 1'b0);
        exp_q.push_back(rep(16'h7FFF));
        start_job(3'd4, 1'b0, 1'b1);
        for (int t = 0; t < 4; t++) send_x(xrep(8'd127), t_acc);
        wait_res(t_res);
        tick();
        exp_q.push_back(rep(16'hE020));
        start_job(3'd7, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) send_x(xrep(8'd127), t_acc);
        wait_res(t_res);
        tick();

        // W = -1, x = 5: ReLU clamps to 0, otherwise -40
        fill_tile(0, 8'hFF, 1'b0);
        exp_q.push_back('0);
        start_job(3'd1, 1'b1, 1'b1);
        send_x(xrep(8'd5), t_acc);
        wait_res(t_res);
        tick();
        exp_q.push_back(rep(16'hFFD8));
        start_job(3'd1, 1'b0, 1'b0);
        send_x(xrep(8'd5), t_acc);
        wait_res(t_res);
        tick();

        // Result back-pressure with an ignored weight write during the stall
        res_ready = 1'b0;
        exp_q.push_back(rep(16'hFFD8));
        start_job(3'd1, 1'b0, 1'b1);
        send_x(xrep(8'd5), t_acc);
        wait_res(t_res);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || res_data !== rep(16'hFFD8) || cfg_ready !== 1'b0 || start_ready !== 1'b0)
                bad = 1'b1;
            if (i == 2) begin
                cfg_valid = 1'b1; cfg_addr = '0; cfg_data = 8'd7;
            end
            if (i == 3) cfg_valid = 1'b0;
            tick();
        end
        check("stall_hold", RW'(bad), '0);
        res_ready = 1'b1;
        tick();
        check("start_ready_after_res", RW'(start_ready), RW'(1));

        // Zero-tile start is ignored
        start_valid = 1'b1; start_tiles = 3'd0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy !== 1'b0 || x_ready !== 1'b0) bad = 1'b1;
        end
        start_valid = 1'b0;
        check("zero_tiles_ignored", RW'(bad), '0);

        // Old weight still in place at tile 0, row 0, col 0
        exp_q.push_back(rep(16'hFFD8));
        start_job(3'd1, 1'b0, 1'b0);
        send_x(xrep(8'd5), t_acc);
        wait_res(t_res);
        tick();

        // Reset in MAC cycle 3 aborts the job and clears the weights
        start_job(3'd1, 1'b0, 1'b0);
        send_x(xrep(8'd1), t_acc);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midjob_reset_ctrl", RW'({cfg_ready, start_ready, x_ready, res_valid, busy}), '0);
        check("midjob_reset_res", res_data, '0);
        tick();
        tick();
        rst = 1'b0;
        check("ready_after_release2", RW'(cfg_ready), '0);
        tick();
        check("ready_first_clock2", RW'({cfg_ready, start_ready}), RW'(2'b11));
        exp_q.push_back('0);
        start_job(3'd1, 1'b0, 1'b0);
        send_x(xrep(8'd1), t_acc);
        wait_res(t_res);
        tick();

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
        check("scoreboard_drain", RW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
